// File: rtl/rgb_convert_arbiter.sv
// Round-robin sharing of one fixed-latency colour->RGB converter between two channels.
// Optional macro RGB_ARB_ERR_EN: flag colour codes 0/7 as invalid instead of converting them.
module rgb_convert_arbiter #(
    parameter int LATENCY  = 2,
    parameter int COLOUR_W = 3,
    parameter int RGB_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic [COLOUR_W-1:0] colour0,
    input  logic                req1,
    input  logic [COLOUR_W-1:0] colour1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                conv_enable,
    output logic [COLOUR_W-1:0] conv_colour,
    input  logic [RGB_W-1:0]    conv_rgb,
    output logic [RGB_W-1:0]    rgb0,
    output logic                vld0,
    output logic [RGB_W-1:0]    rgb1,
    output logic                vld1,
    output logic                err0,
    output logic                err1,
    output logic                busy
);

`ifdef RGB_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                gnt0_q, gnt1_q, last_q;
    logic                conv_en_q;
    logic [COLOUR_W-1:0] conv_colour_q;
    logic [RGB_W-1:0]    rgb0_q, rgb1_q;
    logic                vld0_q, vld1_q, err0_q, err1_q, busy_q;
    logic [LATENCY:0]    trk_v_q, trk_id_q, trk_bad_q;

    logic                elig0, elig1, gnt0_d, gnt1_d, gnt_any, bad_d;
    logic [COLOUR_W-1:0] sel_colour;
    logic [LATENCY:0]    trk_v_d, trk_id_d, trk_bad_d;
    logic                ret_v, ret_id, ret_bad;

    always_comb begin
        // A channel granted this cycle is masked so a held req is not granted twice.
        elig0      = req0 & ~gnt0_q;
        elig1      = req1 & ~gnt1_q;
        // last_q is the most recently granted channel; ties go to the other one.
        gnt0_d     = elig0 & (~elig1 | last_q);
        gnt1_d     = elig1 & (~elig0 | ~last_q);
        gnt_any    = gnt0_d | gnt1_d;
        sel_colour = gnt1_d ? colour1 : colour0;
        bad_d      = ERR_EN && gnt_any &&
                     ((sel_colour == '0) || (sel_colour == COLOUR_W'(7)));
        trk_v_d    = {trk_v_q[LATENCY-1:0],   gnt_any};
        trk_id_d   = {trk_id_q[LATENCY-1:0],  gnt1_d};
        trk_bad_d  = {trk_bad_q[LATENCY-1:0], bad_d};
        ret_v      = trk_v_q[LATENCY];
        ret_id     = trk_id_q[LATENCY];
        ret_bad    = trk_bad_q[LATENCY];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            last_q        <= 1'b1;
            conv_en_q     <= 1'b0;
            conv_colour_q <= '0;
            trk_v_q       <= '0;
            trk_id_q      <= '0;
            trk_bad_q     <= '0;
            rgb0_q        <= '0;
            rgb1_q        <= '0;
            vld0_q        <= 1'b0;
            vld1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            conv_en_q <= gnt_any & ~bad_d;
            if (gnt_any) begin
                last_q        <= gnt1_d;
                conv_colour_q <= sel_colour;
            end
            trk_v_q   <= trk_v_d;
            trk_id_q  <= trk_id_d;
            trk_bad_q <= trk_bad_d;
            // The oldest tracking slot lines up with conv_rgb being valid.
            vld0_q    <= ret_v & ~ret_id;
            vld1_q    <= ret_v & ret_id;
            err0_q    <= ret_v & ~ret_id & ret_bad;
            err1_q    <= ret_v & ret_id & ret_bad;
            if (ret_v && !ret_id) rgb0_q <= ret_bad ? '0 : conv_rgb;
            if (ret_v && ret_id)  rgb1_q <= ret_bad ? '0 : conv_rgb;
            busy_q    <= |trk_v_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign conv_enable = conv_en_q;
    assign conv_colour = conv_colour_q;
    assign rgb0        = rgb0_q;
    assign rgb1        = rgb1_q;
    assign vld0        = vld0_q;
    assign vld1        = vld1_q;
    assign err0        = ERR_EN ? err0_q : 1'b0;
    assign err1        = ERR_EN ? err1_q : 1'b0;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rgb_convert_arbiter.sv
// Directed bench for rgb_convert_arbiter with a ROM model and a grant-order scoreboard.
// Honours RGB_ARB_ERR_EN when it is defined for the build.
module tb_rgb_convert_arbiter;

`ifdef RGB_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [2:0]  colour0, colour1;
    logic        gnt0, gnt1, conv_enable;
    logic [2:0]  conv_colour;
    logic [23:0] conv_rgb;
    logic [23:0] rgb0, rgb1;
    logic        vld0, vld1, err0, err1, busy;

    rgb_convert_arbiter #(.LATENCY(2), .COLOUR_W(3), .RGB_W(24)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .colour0(colour0), .req1(req1), .colour1(colour1),
        .gnt0(gnt0), .gnt1(gnt1),
        .conv_enable(conv_enable), .conv_colour(conv_colour), .conv_rgb(conv_rgb),
        .rgb0(rgb0), .vld0(vld0), .rgb1(rgb1), .vld1(vld1),
        .err0(err0), .err1(err1), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom(input logic [2:0] c);
        case (c)
            3'd1:    return 24'hFF0000;
            3'd2:    return 24'h00FF00;
            3'd3:    return 24'h0000FF;
            3'd4:    return 24'hFFFF00;
            3'd5:    return 24'h00FFFF;
            3'd6:    return 24'hFF00FF;
            3'd0:    return 24'h123456;
            default: return 24'hABCDEF;
        endcase
    endfunction

    function automatic logic is_bad(input logic [2:0] c);
        return ERR_EN && (c == 3'd0 || c == 3'd7);
    endfunction

    // Converter model: two-cycle read latency, junk when not enabled.
    logic [23:0] rom_s1, rom_s2;
    always @(posedge clk) begin
        rom_s1 <= conv_enable ? rom(conv_colour) : 24'hBAD0BA;
        rom_s2 <= rom_s1;
    end
    assign conv_rgb = rom_s2;

    typedef struct { logic ch; logic [23:0] rgb; logic err; } exp_t;
    exp_t sb[$];
    int npass = 0, nfail = 0, ntot = 0;
    int nv0 = 0, nv1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sb.delete();
        tick(); tick();
        rst = 1'b0;
    endtask

    // Scoreboard: expected words queued at each grant, popped at each vld pulse.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (gnt0) sb.push_back('{1'b0, is_bad(colour0) ? 24'h0 : rom(colour0), is_bad(colour0)});
            if (gnt1) sb.push_back('{1'b1, is_bad(colour1) ? 24'h0 : rom(colour1), is_bad(colour1)});
            if (vld0 || vld1) begin
                if (vld0) nv0++;
                if (vld1) nv1++;
                chk("vld_excl", 32'(vld0 & vld1), 0);
                chk("sb_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_ch", 32'(vld1), 32'(e.ch));
                    chk("sb_rgb", 32'(vld1 ? rgb1 : rgb0), 32'(e.rgb));
                    chk("sb_err", 32'(vld1 ? err1 : err0), 32'(e.err));
                end
            end
        end
    end

    int v0_snap, v1_snap;

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; colour0 = 3'd1; colour1 = 3'd2;

        // Reset held with both requests active
        tick(); tick();
        @(negedge clk);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_conv", {conv_enable, conv_colour}, 0);
        chk("rst_vld_err", {vld0, vld1, err0, err1}, 0);
        chk("rst_rgb0", rgb0, 0);
        chk("rst_rgb1", rgb1, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick(); req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("first_gnt", {gnt0, gnt1}, 2'b10);
        repeat (8) tick();

        // Single request on channel 0, colour 1
        req0 = 1'b1; colour0 = 3'd1;
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("single_gnt0", gnt0, 1);
        chk("single_conv", {conv_enable, conv_colour}, {1'b1, 3'd1});
        chk("single_busy1", busy, 1);
        tick(); @(negedge clk);
        chk("single_nodup", {gnt0, conv_enable}, 0);
        chk("single_hold_colour", conv_colour, 1);
        tick(); @(negedge clk);
        chk("single_busy3", busy, 1);
        tick(); @(negedge clk);
        chk("single_vld0", vld0, 1);
        chk("single_rgb0", rgb0, 24'hFF0000);
        tick(); @(negedge clk);
        chk("single_vld0_done", vld0, 0);
        chk("single_busy5", busy, 0);
        chk("single_rgb0_held", rgb0, 24'hFF0000);
        repeat (3) tick();

        // Simultaneous requests from a freshly reset pointer
        do_reset();
        req0 = 1'b1; colour0 = 3'd2; req1 = 1'b1; colour1 = 3'd5;
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("simul_c1_gnt", {gnt0, gnt1}, 2'b10);
        chk("simul_c1_colour", conv_colour, 2);
        tick(); req1 = 1'b0;
        @(negedge clk);
        chk("simul_c2_gnt", {gnt0, gnt1}, 2'b01);
        chk("simul_c2_colour", conv_colour, 5);
        tick(); tick(); @(negedge clk);
        chk("simul_c4_vld", {vld0, vld1}, 2'b10);
        chk("simul_c4_rgb0", rgb0, 24'h00FF00);
        tick(); @(negedge clk);
        chk("simul_c5_vld", {vld0, vld1}, 2'b01);
        chk("simul_c5_rgb1", rgb1, 24'h00FFFF);
        chk("simul_c5_rgb0_held", rgb0, 24'h00FF00);
        repeat (6) tick();

        // Sustained contention: both requests held for 8 cycles
        v0_snap = nv0; v1_snap = nv1;
        req0 = 1'b1; colour0 = 3'd3; req1 = 1'b1; colour1 = 3'd4;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
            chk($sformatf("sust_gnt_c%0d", k), {gnt0, gnt1}, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk($sformatf("sust_en_c%0d", k), conv_enable, 1);
        end
        repeat (8) tick();
        chk("sust_vld0_count", nv0 - v0_snap, 4);
        chk("sust_vld1_count", nv1 - v1_snap, 4);
        chk("sust_idle", busy, 0);

        // Reset while a channel-1 lookup is in flight
        v1_snap = nv1;
        req1 = 1'b1; colour1 = 3'd6;
        tick(); req1 = 1'b0;
        @(negedge clk);
        chk("midrst_gnt1", gnt1, 1);
        tick(); rst = 1'b1; sb.delete();
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_rgb1", rgb1, 0);
        chk("midrst_vld1", vld1, 0);
        repeat (6) tick();
        chk("midrst_no_vld1", nv1 - v1_snap, 0);

        // Colour 7 on channel 0: invalid only with the error feature built in
        req0 = 1'b1; colour0 = 3'd7;
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("c7_gnt0", gnt0, 1);
        chk("c7_conv_en", conv_enable, ERR_EN ? 0 : 1);
        chk("c7_colour", conv_colour, 7);
        tick(); tick(); tick(); @(negedge clk);
        chk("c7_vld0", vld0, 1);
        chk("c7_err0", err0, ERR_EN ? 1 : 0);
        chk("c7_rgb0", rgb0, ERR_EN ? 24'h0 : 24'hABCDEF);
        tick(); @(negedge clk);
        chk("c7_err0_pulse", err0, 0);
        repeat (4) tick();

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
